// File: rtl/fetch_unit_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_IDLE    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_e;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory port, redirect and instruction-stream signals of the fetch unit.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
);

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;

   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;

   logic              ins_valid;
   logic              ins_ready;
   logic [DATA_W-1:0] ins_out;
   logic [ADDR_W-1:0] ins_pc;
   logic [ptr_w(DEPTH):0] count;

   modport master (
      output mem_req, mem_addr, ins_valid, ins_out, ins_pc, count,
      input  mem_ack, mem_data, redirect, redirect_addr, ins_ready
   );

   modport slave (
      input  mem_req, mem_addr, ins_valid, ins_out, ins_pc, count,
      output mem_ack, mem_data, redirect, redirect_addr, ins_ready
   );

endinterface

// File: rtl/fetch_unit_prefetch_fifo.sv
// Circular prefetch queue of {pc, word} entries with flush and occupancy count.
module fetch_unit_prefetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [PTR_W:0]   count
);

   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush && (count != CNT_W'(DEPTH));
   assign do_pop  = pop  && !flush && (count != '0);
   assign rdata   = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: storage has no reset; an entry is only read after count says it was written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction prefetcher with branch redirect and stale-response discard.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_state_e             state;
   logic [ADDR_W-1:0]        fetch_pc;
   logic [ADDR_W-1:0]        saved_redirect;
   logic [CNT_W-1:0]         count;
   logic [CNT_W-1:0]         count_next;
   logic [ADDR_W+DATA_W-1:0] head;
   logic                     ack;
   logic                     push;
   logic                     pop;

   // An acknowledge only counts against a request we are actually driving.
   assign ack        = bus.mem_ack && bus.mem_req;
   assign push       = (state == S_FETCH) && ack && !bus.redirect;
   assign pop        = bus.ins_valid && bus.ins_ready && !bus.redirect;
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   fetch_unit_prefetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (bus.redirect),
      .push  (push),
      .pop   (pop),
      .wdata ({fetch_pc, bus.mem_data}),
      .rdata (head),
      .count (count)
   );

   assign bus.ins_valid = (count != '0);
   assign bus.ins_pc    = head[ADDR_W+DATA_W-1:DATA_W];
   assign bus.ins_out   = head[DATA_W-1:0];
   assign bus.count     = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_FETCH;
         fetch_pc       <= RESET_PC;
         saved_redirect <= RESET_PC;
         bus.mem_req    <= 1'b0;
         bus.mem_addr   <= RESET_PC;
      end else if (bus.redirect) begin
         case (state)
            S_DISCARD: saved_redirect <= bus.redirect_addr;
            S_FETCH: begin
               if (bus.mem_req && !bus.mem_ack) begin
                  // Request in flight: keep its address stable and swallow the reply.
                  state          <= S_DISCARD;
                  saved_redirect <= bus.redirect_addr;
               end else begin
                  fetch_pc     <= bus.redirect_addr;
                  bus.mem_addr <= bus.redirect_addr;
                  bus.mem_req  <= 1'b1;
               end
            end
            default: begin
               state        <= S_FETCH;
               fetch_pc     <= bus.redirect_addr;
               bus.mem_addr <= bus.redirect_addr;
               bus.mem_req  <= 1'b1;
            end
         endcase
      end else begin
         case (state)
            S_FETCH: begin
               bus.mem_req <= 1'b1;
               if (ack) begin
                  fetch_pc     <= fetch_pc + ADDR_W'(1);
                  bus.mem_addr <= fetch_pc + ADDR_W'(1);
                  if (count_next >= CNT_W'(DEPTH)) begin
                     state       <= S_IDLE;
                     bus.mem_req <= 1'b0;
                  end
               end
            end
            S_IDLE: begin
               if (count_next < CNT_W'(DEPTH)) begin
                  state       <= S_FETCH;
                  bus.mem_req <= 1'b1;
               end
            end
            S_DISCARD: begin
               if (ack) begin
                  state        <= S_FETCH;
                  fetch_pc     <= saved_redirect;
                  bus.mem_addr <= saved_redirect;
               end
            end
            default: begin
               state       <= S_FETCH;
               bus.mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenario bench for fetch_unit: streaming, full queue, redirects, wrap, async reset.
module tb_fetch_unit;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   n_compared   = 0;
   int   n_mismatched = 0;

   fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();

   fetch_unit #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .DEPTH    (DEPTH),
      .RESET_PC (16'h0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return a ^ 16'h5A3C;
   endfunction

   task automatic drive_idle();
      bus.mem_ack       = 1'b0;
      bus.mem_data      = '0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      bus.ins_ready     = 1'b0;
   endtask

   // Leaves the bench at the negedge where reset is released.
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [19:0] got;
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      got = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if (got !== {1'b0, 16'h0000, 3'd0}) begin
         n_mismatched++;
         $display("FAIL reset_hold {req,addr,count}: got %h expected %h", got, {1'b0, 16'h0000, 3'd0});
      end
      n_compared++;
      if (bus.ins_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL reset_valid: got %b expected 0", bus.ins_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
      got = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if (got !== {1'b1, 16'h0000, 3'd0}) begin
         n_mismatched++;
         $display("FAIL reset_first_req: got %h expected %h", got, {1'b1, 16'h0000, 3'd0});
      end
   endtask

   task automatic test_stream();
      logic [19:0] got_m, exp_m;
      logic [32:0] got_i, exp_i;
      apply_reset();
      bus.ins_ready = 1'b1;
      bus.mem_ack   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.mem_data = mem_word(bus.mem_addr);
         got_m = {bus.mem_req, bus.mem_addr, bus.count};
         exp_m = {1'b1, AW'(i), (i == 0) ? 3'd0 : 3'd1};
         n_compared++;
         if (got_m !== exp_m) begin
            n_mismatched++;
            $display("FAIL stream_mem[%0d]: got %h expected %h", i, got_m, exp_m);
         end
         if (i >= 1) begin
            got_i = {bus.ins_valid, bus.ins_pc, bus.ins_out};
            exp_i = {1'b1, AW'(i - 1), mem_word(AW'(i - 1))};
            n_compared++;
            if (got_i !== exp_i) begin
               n_mismatched++;
               $display("FAIL stream_ins[%0d]: got %h expected %h", i, got_i, exp_i);
            end
         end
      end
   endtask

   task automatic test_full();
      logic [19:0] got_m, exp_m;
      logic [32:0] got_i, exp_i;
      apply_reset();
      bus.mem_ack   = 1'b1;
      bus.ins_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.mem_data = mem_word(bus.mem_addr);
         got_m = {bus.mem_req, bus.mem_addr, bus.count};
         exp_m = {1'b1, AW'(i), CW'(i)};
         n_compared++;
         if (got_m !== exp_m) begin
            n_mismatched++;
            $display("FAIL full_fill[%0d]: got %h expected %h", i, got_m, exp_m);
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got_m = {bus.mem_req, bus.mem_addr, bus.count};
         exp_m = {1'b0, 16'h0004, 3'd4};
         n_compared++;
         if (got_m !== exp_m) begin
            n_mismatched++;
            $display("FAIL full_stall[%0d]: got %h expected %h", i, got_m, exp_m);
         end
      end
      bus.ins_ready = 1'b1;
      @(negedge clk);
      bus.ins_ready = 1'b0;
      bus.mem_data  = mem_word(bus.mem_addr);
      got_m = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if (got_m !== {1'b1, 16'h0004, 3'd3}) begin
         n_mismatched++;
         $display("FAIL full_refetch: got %h expected %h", got_m, {1'b1, 16'h0004, 3'd3});
      end
      @(negedge clk);
      got_m = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if (got_m !== {1'b0, 16'h0005, 3'd4}) begin
         n_mismatched++;
         $display("FAIL full_refill: got %h expected %h", got_m, {1'b0, 16'h0005, 3'd4});
      end
      bus.mem_ack   = 1'b0;
      bus.ins_ready = 1'b1;
      for (int j = 2; j <= 4; j++) begin
         @(negedge clk);
         got_i = {bus.ins_valid, bus.ins_pc, bus.ins_out};
         exp_i = {1'b1, AW'(j), mem_word(AW'(j))};
         n_compared++;
         if (got_i !== exp_i) begin
            n_mismatched++;
            $display("FAIL full_drain_ins[%0d]: got %h expected %h", j, got_i, exp_i);
         end
         n_compared++;
         if (bus.count !== CW'(5 - j)) begin
            n_mismatched++;
            $display("FAIL full_drain_count[%0d]: got %0d expected %0d", j, bus.count, 5 - j);
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got_m = {bus.mem_req, bus.mem_addr, bus.count};
         n_compared++;
         if ({bus.ins_valid, got_m} !== {1'b0, 1'b1, 16'h0005, 3'd0}) begin
            n_mismatched++;
            $display("FAIL full_empty[%0d]: valid %b {req,addr,count} %h expected 0 / %h", i, bus.ins_valid, got_m, {1'b1, 16'h0005, 3'd0});
         end
      end
   endtask

   task automatic test_redirect_wait();
      logic [19:0] got_m;
      logic [32:0] got_i;
      apply_reset();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      bus.mem_ack  = 1'b1;
      bus.mem_data = mem_word(16'h0000);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      got_m = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if (got_m !== {1'b1, 16'h0001, 3'd1}) begin
         n_mismatched++;
         $display("FAIL rwait_pre: got %h expected %h", got_m, {1'b1, 16'h0001, 3'd1});
      end
      bus.redirect      = 1'b1;
      bus.redirect_addr = 16'h0040;
      @(negedge clk);
      bus.redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (i == 1) @(negedge clk);
         got_m = {bus.mem_req, bus.mem_addr, bus.count};
         n_compared++;
         if ({bus.ins_valid, got_m} !== {1'b0, 1'b1, 16'h0001, 3'd0}) begin
            n_mismatched++;
            $display("FAIL rwait_hold[%0d]: valid %b {req,addr,count} %h expected 0 / %h", i, bus.ins_valid, got_m, {1'b1, 16'h0001, 3'd0});
         end
      end
      bus.mem_ack  = 1'b1;
      bus.mem_data = mem_word(16'h0001);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      got_m = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if ({bus.ins_valid, got_m} !== {1'b0, 1'b1, 16'h0040, 3'd0}) begin
         n_mismatched++;
         $display("FAIL rwait_restart: valid %b {req,addr,count} %h expected 0 / %h", bus.ins_valid, got_m, {1'b1, 16'h0040, 3'd0});
      end
      @(negedge clk);
      @(negedge clk);
      bus.mem_ack  = 1'b1;
      bus.mem_data = mem_word(16'h0040);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      got_i = {bus.ins_valid, bus.ins_pc, bus.ins_out};
      n_compared++;
      if (got_i !== {1'b1, 16'h0040, mem_word(16'h0040)}) begin
         n_mismatched++;
         $display("FAIL rwait_first_ins: got %h expected %h", got_i, {1'b1, 16'h0040, mem_word(16'h0040)});
      end
      n_compared++;
      if (bus.mem_addr !== 16'h0041) begin
         n_mismatched++;
         $display("FAIL rwait_next_addr: got %h expected 0041", bus.mem_addr);
      end
   endtask

   task automatic test_redirect_ack();
      logic [19:0] got_m;
      logic [32:0] got_i;
      apply_reset();
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_data = mem_word(bus.mem_addr);
      @(negedge clk);
      got_m = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if (got_m !== {1'b1, 16'h0001, 3'd1}) begin
         n_mismatched++;
         $display("FAIL rack_pre: got %h expected %h", got_m, {1'b1, 16'h0001, 3'd1});
      end
      bus.mem_data      = mem_word(16'h0001);
      bus.redirect      = 1'b1;
      bus.redirect_addr = 16'h0100;
      @(negedge clk);
      bus.redirect = 1'b0;
      bus.mem_data = mem_word(bus.mem_addr);
      got_m = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if ({bus.ins_valid, got_m} !== {1'b0, 1'b1, 16'h0100, 3'd0}) begin
         n_mismatched++;
         $display("FAIL rack_flush: valid %b {req,addr,count} %h expected 0 / %h", bus.ins_valid, got_m, {1'b1, 16'h0100, 3'd0});
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      got_i = {bus.ins_valid, bus.ins_pc, bus.ins_out};
      n_compared++;
      if (got_i !== {1'b1, 16'h0100, mem_word(16'h0100)}) begin
         n_mismatched++;
         $display("FAIL rack_first_ins: got %h expected %h", got_i, {1'b1, 16'h0100, mem_word(16'h0100)});
      end
   endtask

   task automatic test_wrap();
      logic [32:0] got_i, exp_i;
      logic [AW-1:0] exp_pc;
      apply_reset();
      bus.mem_ack   = 1'b1;
      bus.ins_ready = 1'b1;
      @(negedge clk);
      bus.redirect      = 1'b1;
      bus.redirect_addr = 16'hFFFE;
      @(negedge clk);
      bus.redirect = 1'b0;
      bus.mem_data = mem_word(bus.mem_addr);
      n_compared++;
      if (bus.mem_addr !== 16'hFFFE) begin
         n_mismatched++;
         $display("FAIL wrap_start_addr: got %h expected fffe", bus.mem_addr);
      end
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         bus.mem_data = mem_word(bus.mem_addr);
         exp_pc = 16'hFFFE + AW'(j);
         got_i = {bus.ins_valid, bus.ins_pc, bus.ins_out};
         exp_i = {1'b1, exp_pc, mem_word(exp_pc)};
         n_compared++;
         if (got_i !== exp_i) begin
            n_mismatched++;
            $display("FAIL wrap_ins[%0d]: got %h expected %h", j, got_i, exp_i);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [19:0] got_m;
      apply_reset();
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.mem_data = mem_word(bus.mem_addr);
      end
      got_m = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if (got_m !== {1'b1, 16'h0003, 3'd3}) begin
         n_mismatched++;
         $display("FAIL areset_pre: got %h expected %h", got_m, {1'b1, 16'h0003, 3'd3});
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_compared++;
      if ({bus.ins_valid, bus.mem_req, bus.count} !== {1'b0, 1'b0, 3'd0}) begin
         n_mismatched++;
         $display("FAIL areset_immediate {valid,req,count}: got %b expected 0000", {bus.ins_valid, bus.mem_req, bus.count});
      end
      @(negedge clk);
      n_compared++;
      if ({bus.ins_valid, bus.mem_req, bus.count} !== {1'b0, 1'b0, 3'd0}) begin
         n_mismatched++;
         $display("FAIL areset_held {valid,req,count}: got %b expected 0000", {bus.ins_valid, bus.mem_req, bus.count});
      end
      rst_n = 1'b1;
      @(negedge clk);
      bus.mem_data = mem_word(bus.mem_addr);
      got_m = {bus.mem_req, bus.mem_addr, bus.count};
      n_compared++;
      if (got_m !== {1'b1, 16'h0000, 3'd0}) begin
         n_mismatched++;
         $display("FAIL areset_restart: got %h expected %h", got_m, {1'b1, 16'h0000, 3'd0});
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      n_compared++;
      if ({bus.ins_valid, bus.ins_pc, bus.count} !== {1'b1, 16'h0000, 3'd1}) begin
         n_mismatched++;
         $display("FAIL areset_first_ins {valid,pc,count}: got %h expected %h", {bus.ins_valid, bus.ins_pc, bus.count}, {1'b1, 16'h0000, 3'd1});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_ack();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction fetch unit. It decouples the CPU controller from memory latency by prefetching sequential instruction words into a small queue. It sits between the memory port and the instruction register / controller. It supports branch redirect with queue flush and discard of an in-flight response, which the current fixed single-word fetch path does not.

Parameters:
DATA_W, 16, instruction/memory data width in bits
ADDR_W, 16, word address width; PC wraps modulo 2^ADDR_W
DEPTH, 4, prefetch queue entries (power of two, >= 2)
RESET_PC, 0, fetch address loaded on reset

Ports:
Clock  input  1  sole clock, rising edge
Reset  input  1  asynchronous, active-low reset
Mem_Req  output  1  fetch request; held high until Mem_Ack
Mem_Addr  output  ADDR_W  word address of current request; stable while Mem_Req=1
Mem_Ack  input  1  memory returns Mem_Data this cycle; only meaningful while Mem_Req=1
Mem_Data  input  DATA_W  read data, valid with Mem_Ack
Redirect  input  1  one-cycle pulse: flush and restart fetch at Redirect_Addr
Redirect_Addr  input  ADDR_W  new fetch address, sampled when Redirect=1
Ins_Valid  output  1  queue head holds a valid instruction
Ins_Ready  input  1  consumer accepts head when Ins_Valid=1
Ins_Out  output  DATA_W  head instruction word
Ins_PC  output  ADDR_W  address the head word was fetched from
Count  output  clog2(DEPTH)+1  current queue occupancy, for debug and PSR-side stall logic

Behaviour:
- Reset (Reset=0, async): state=FETCH; fetch_pc=RESET_PC; queue empty; Mem_Req=1 after the first edge following reset release; Mem_Addr=RESET_PC; Ins_Valid=0; Count=0.
- fetch_pc, Mem_Req and Mem_Addr are registered. Mem_Addr always equals fetch_pc, except in DISCARD, where it holds the stale address.
- States:
  - FETCH: Mem_Req=1. On Mem_Ack, push {fetch_pc, Mem_Data} and set fetch_pc+1. Stay in FETCH if occupancy after the push and any same-cycle pop is < DEPTH; otherwise go to IDLE.
  - IDLE: Mem_Req=0. Go to FETCH when occupancy < DEPTH, i.e. the cycle after a pop frees a slot.
  - DISCARD: Mem_Req=1, Mem_Addr held at the old address. On Mem_Ack, drop the data, load fetch_pc from saved_redirect, and go to FETCH.
- Pop: occurs when Ins_Valid && Ins_Ready. Ins_Out and Ins_PC are combinational from the head entry. Push-to-Ins_Valid latency is 1 cycle.
- Redirect has priority over push, pop and state:
  - Flush the queue; Count=0 next cycle.
  - FETCH without Mem_Ack this cycle: go to DISCARD; save Redirect_Addr.
  - FETCH with Mem_Ack this cycle: drop the data; fetch_pc=Redirect_Addr; stay in FETCH.
  - IDLE: fetch_pc=Redirect_Addr; go to FETCH.
  - DISCARD: overwrite the saved address; remain in DISCARD.
- Full: no request is issued when full. Push and pop in the same cycle at Count=DEPTH-1 or DEPTH keep occupancy legal; a push never occurs while full.
- Empty: Ins_Valid=0; Ins_Ready is ignored.
- Wrap: fetch_pc=2^ADDR_W-1 increments to 0; the entry PC records the pre-increment value.
- Reset mid-transaction: all state clears immediately. Any later Mem_Ack while Mem_Req=0 is ignored.
- Mem_Ack while Mem_Req=0 is ignored in every state.

Decomposition:
- Shared package holds the state encoding (FETCH, IDLE, DISCARD) and the PTR_W = clog2(DEPTH) helper.
- Natural sub-module: prefetch_fifo. It is a DEPTH x (ADDR_W+DATA_W) circular buffer with push, pop, flush, count, and wrap-around read/write pointers.
- The FSM and fetch_pc live in fetch_unit.

Test Plan:
- Reset release, memory acks every cycle, Ins_Ready=1:
  - Mem_Addr sequence is 0,1,2,…
  - Ins_PC/Ins_Out stream matches, 1-cycle lag, no gaps.
- Ins_Ready=0, zero-latency memory:
  - Exactly 4 pushes (addresses 0–3), then Mem_Req=0 and Count=4.
  - One pop → Mem_Req=1 at address 4 the next cycle.
- Memory with 3-cycle ack latency and Redirect to 0x0040 during wait:
  - Mem_Addr holds the old address until ack; that data never appears on Ins_Out.
  - Next request is 0x0040; Count=0 after the flush.
- Redirect to 0x0100 coincident with Mem_Ack:
  - Acked word dropped.
  - Next Mem_Addr=0x0100; first Ins_PC=0x0100.
- Redirect_Addr=0xFFFE, continuous acks:
  - Ins_PC sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Async reset asserted while Count=3 and Mem_Req=1:
  - Ins_Valid=0, Count=0 and Mem_Req=0 immediately.
  - Fetch restarts at RESET_PC after release.
